// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with one-entry completion slots per unit
module cdb_arbiter #(
    parameter int NUM_FU = 5,
    parameter int TAG_W  = 6,
    parameter int SRC_W  = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic [NUM_FU-1:0]       fu_done_valid,
    input  logic [NUM_FU*TAG_W-1:0] fu_done_tag,
    output logic [NUM_FU-1:0]       fu_ready,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [SRC_W-1:0]        cdb_src
);

    logic [NUM_FU-1:0] slot_valid;
    logic [TAG_W-1:0]  slot_tag [NUM_FU];
    logic [SRC_W-1:0]  rr_ptr;

    logic [NUM_FU-1:0] grant;
    logic              win_found;
    logic [SRC_W-1:0]  win_idx;
    logic [TAG_W-1:0]  win_tag;

    // Position of the k-th candidate in the scan that starts at the pointer.
    function automatic int scan_pos(input logic [SRC_W-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        return (s >= NUM_FU) ? (s - NUM_FU) : s;
    endfunction

    always_comb begin
        grant     = '0;
        win_found = 1'b0;
        win_idx   = '0;
        win_tag   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (!win_found && (i == scan_pos(rr_ptr, k)) && slot_valid[i]) begin
                    win_found = 1'b1;
                    grant[i]  = 1'b1;
                    win_idx   = SRC_W'(i);
                    win_tag   = slot_tag[i];
                end
            end
        end
    end

    // A slot that is draining this cycle can take a new result at the same edge.
    assign fu_ready = flush ? '0 : (~slot_valid | grant);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                slot_tag[i] <= '0;
            end
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_src   <= '0;
        end else if (flush) begin
            slot_valid <= '0;
            cdb_valid  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_done_valid[i] && fu_ready[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_tag[i]   <= fu_done_tag[i*TAG_W +: TAG_W];
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
            cdb_valid <= win_found;
            if (win_found) begin
                cdb_tag <= win_tag;
                cdb_src <= win_idx;
                rr_ptr  <= (win_idx == SRC_W'(NUM_FU - 1)) ? '0 : win_idx + SRC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter with a behavioural slot/pointer model
module tb_cdb_arbiter;
    localparam int N  = 5;
    localparam int TW = 6;
    localparam int SW = 3;

    logic            clock = 1'b0;
    logic            reset_n = 1'b1;
    logic            flush = 1'b0;
    logic [N-1:0]    fu_done_valid = '0;
    logic [N*TW-1:0] fu_done_tag = '0;
    logic [N-1:0]    fu_ready;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [SW-1:0]   cdb_src;

    cdb_arbiter #(.NUM_FU(N), .TAG_W(TW), .SRC_W(SW)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .fu_done_valid(fu_done_valid), .fu_done_tag(fu_done_tag),
        .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_src(cdb_src)
    );

    always #5 clock = ~clock;

    typedef struct { int edge_no; int tag; int src; } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int edge_no = 0;

    int m_valid [N];
    int m_tag   [N];
    int m_acc   [N];
    int m_ptr;

    int hold_tag = 0;
    int hold_src = 0;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, want, edge_no);
        end
    endtask

    function automatic int model_winner();
        int w;
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && m_valid[(m_ptr + k) % N] != 0) w = (m_ptr + k) % N;
        end
        return w;
    endfunction

    function automatic int model_ready(input logic fl);
        int w, r;
        w = model_winner();
        r = 0;
        if (!fl) begin
            for (int i = 0; i < N; i++) begin
                if (m_valid[i] == 0 || i == w) r |= (1 << i);
            end
        end
        return r;
    endfunction

    task automatic model_step(input logic [N-1:0] v, input logic [N*TW-1:0] t, input logic fl);
        int w;
        edge_no++;
        for (int i = 0; i < N; i++) m_acc[i] = 0;
        if (fl) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
        end else begin
            w = model_winner();
            if (w >= 0) begin
                exp_q.push_back('{edge_no, m_tag[w], w});
                m_ptr = (w + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && (m_valid[i] == 0 || i == w)) begin
                    m_valid[i] = 1;
                    m_tag[i]   = int'(t[i*TW +: TW]);
                    m_acc[i]   = 1;
                end else if (i == w) begin
                    m_valid[i] = 0;
                end
            end
        end
    endtask

    // Entered and left at one time unit after a rising edge.
    task automatic cycle(input logic [N-1:0] v, input logic [N*TW-1:0] t, input logic fl);
        fu_done_valid = v;
        fu_done_tag   = t;
        flush         = fl;
        #1;
        chk("fu_ready", int'(fu_ready), model_ready(fl));
        @(posedge clock);
        model_step(v, t, fl);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b0);
    endtask

    task automatic do_reset();
        fu_done_valid = '0;
        fu_done_tag   = '0;
        flush         = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_cdb_valid", int'(cdb_valid), 0);
        chk("rst_cdb_tag", int'(cdb_tag), 0);
        chk("rst_cdb_src", int'(cdb_src), 0);
        chk("rst_fu_ready", int'(fu_ready), 31);
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_ptr = 0;
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        model_step('0, '0, 1'b0);
        #1;
    endtask

    // Monitor: every broadcast must match the oldest predicted one, including its edge.
    initial forever begin
        @(negedge clock or negedge reset_n);
        if (!reset_n) begin
            exp_q.delete();
            hold_tag = 0;
            hold_src = 0;
        end else if (cdb_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL cdb_spurious: got tag %0d src %0d, expected no broadcast (edge %0d)",
                         cdb_tag, cdb_src, edge_no);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cdb_edge", edge_no, e.edge_no);
                chk("cdb_tag", int'(cdb_tag), e.tag);
                chk("cdb_src", int'(cdb_src), e.src);
                hold_tag = e.tag;
                hold_src = e.src;
            end
        end else begin
            chk("idle_tag_hold", int'(cdb_tag), hold_tag);
            chk("idle_src_hold", int'(cdb_src), hold_src);
        end
    end

    initial begin
        logic [N*TW-1:0] t;
        int ld_t, fp2_t;
        int pend_v [N];
        int pend_t [N];
        logic [N-1:0] v;
        logic fl;

        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_acc[i] = 0; pend_v[i] = 0; pend_t[i] = 0;
        end
        m_ptr = 0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("init_cdb_valid", int'(cdb_valid), 0);
        chk("init_cdb_tag", int'(cdb_tag), 0);
        chk("init_cdb_src", int'(cdb_src), 0);
        chk("init_fu_ready", int'(fu_ready), 31);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        model_step('0, '0, 1'b0);
        #1;
        idle(3);

        // Single ALU result
        t = '0; t[0 +: TW] = TW'(17);
        cycle(5'b00001, t, 1'b0);
        idle(4);

        // All five units at once from pointer 0, then a two-unit probe of the wrapped pointer
        do_reset();
        t = '0;
        for (int i = 0; i < N; i++) t[i*TW +: TW] = TW'(10 + i);
        cycle(5'b11111, t, 1'b0);
        idle(6);
        t = '0; t[0 +: TW] = TW'(50); t[TW +: TW] = TW'(51);
        cycle(5'b00011, t, 1'b0);
        idle(3);

        // FP1 back to back
        for (int k = 0; k < 3; k++) begin
            t = '0; t[3*TW +: TW] = TW'(20 + k);
            cycle(5'b01000, t, 1'b0);
        end
        idle(3);

        // LD and FP2 contending, new tag after each acceptance
        ld_t = 30; fp2_t = 45;
        for (int k = 0; k < 12; k++) begin
            t = '0; t[1*TW +: TW] = TW'(ld_t); t[4*TW +: TW] = TW'(fp2_t);
            cycle(5'b10010, t, 1'b0);
            if (m_acc[1] != 0) ld_t++;
            if (m_acc[4] != 0) fp2_t++;
        end
        idle(3);

        // Flush with slots 0 and 3 full and ALU presenting tag 30
        t = '0; t[0 +: TW] = TW'(40); t[3*TW +: TW] = TW'(43);
        cycle(5'b01001, t, 1'b0);
        t = '0; t[0 +: TW] = TW'(30);
        cycle(5'b00001, t, 1'b1);
        idle(3);
        t = '0;
        for (int i = 0; i < N; i++) t[i*TW +: TW] = TW'(1 + i);
        cycle(5'b11111, t, 1'b0);
        idle(6);

        // Randomized traffic; a unit keeps its offer until accepted
        for (int k = 0; k < 400; k++) begin
            if (k == 200) do_reset();
            fl = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < N; i++) begin
                if (pend_v[i] == 0 && $urandom_range(0, 99) < 45) begin
                    pend_v[i] = 1;
                    pend_t[i] = int'($urandom_range(0, 63));
                end
            end
            v = '0; t = '0;
            for (int i = 0; i < N; i++) begin
                v[i] = (pend_v[i] != 0);
                t[i*TW +: TW] = TW'(pend_t[i]);
            end
            cycle(v, t, fl);
            for (int i = 0; i < N; i++) begin
                if (m_acc[i] != 0 || fl) pend_v[i] = 0;
            end
        end
        idle(8);

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion-side scheduler that shares the single common data bus (CDB) among the functional units fed by the reservation station: ALU, LD, ST, FP1 and FP2. Each unit hands its finished destination tag to a one-entry holding slot. A round-robin arbiter grants one slot per cycle. The winning tag is driven on a registered CDB, which the reservation station, map table and ROB use for wakeup. Per-unit ready signals back-pressure a unit whose slot cannot drain.

## Interface

Parameters:
- NUM_FU, default 5: number of requesting units; index 0 ALU, 1 LD, 2 ST, 3 FP1, 4 FP2.
- TAG_W, default 6: physical-register tag width.
- SRC_W, default 3: width of grant index; must satisfy 2^SRC_W ≥ NUM_FU.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous squash (branch mispredict recovery).
- fu_done_valid  in  NUM_FU  unit i presents a completed result.
- fu_done_tag  in  NUM_FU×TAG_W  destination tag per unit.
- fu_ready  out  NUM_FU  unit i's result is accepted this cycle if fu_done_valid[i].
- cdb_valid  out  1  CDB carries a tag this cycle.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_src  out  SRC_W  index of the unit that produced cdb_tag.

## Operation

- State:
  - per-unit slot_valid[i] and slot_tag[i];
  - round-robin pointer rr_ptr (0..NUM_FU-1);
  - registered cdb_valid, cdb_tag and cdb_src.
- Request vector is req[i] = slot_valid[i].
- Grant (combinational):
  - scan indices rr_ptr, rr_ptr+1, … modulo NUM_FU;
  - the first i with req[i] wins, giving grant[i] = 1;
  - at most one grant per cycle; no grant when req is zero.
- fu_ready[i] = !flush && (!slot_valid[i] || grant[i]). A slot being drained may be refilled in the same cycle.
- Slot update at edge:
  - accept (fu_done_valid[i] && fu_ready[i]) sets slot_valid[i] = 1 and slot_tag[i] = fu_done_tag[i];
  - otherwise grant[i] clears slot_valid[i];
  - otherwise the slot holds.
- CDB update at edge:
  - cdb_valid = |grant; cdb_tag = slot_tag of the winner; cdb_src = winner index;
  - when there is no grant, cdb_valid = 0, and cdb_tag/cdb_src hold their previous values.
- Pointer update at edge:
  - on a grant to i, rr_ptr = (i+1) mod NUM_FU (wrap from NUM_FU-1 to 0);
  - with no grant, rr_ptr holds.
- Flush, at the next edge:
  - all slot_valid cleared and cdb_valid = 0;
  - fu_ready is 0 throughout the flush cycle, so inputs presented that cycle are dropped;
  - rr_ptr is unchanged.
- A unit must not change fu_done_tag while fu_done_valid=1 and fu_ready=0.
- Fairness: a valid slot is granted within NUM_FU cycles of becoming valid, absent flush.
- Tag value 0 is broadcast like any other tag; no tag filtering.

## Timing

- Reset (reset_n low, immediate and asynchronous):
  - slot_valid = 0, rr_ptr = 0;
  - cdb_valid = 0, cdb_tag = 0, cdb_src = 0;
  - hence fu_ready is all-ones once flush = 0.
- Latency: a result accepted at edge E appears on the CDB in the cycle after edge E+1, i.e. 2 edges from acceptance to broadcast.
- Throughput: one broadcast per cycle aggregate. A single unit alone sustains one result per cycle through drain-and-refill.
- Reset mid-operation: all pending results are discarded, and there is no broadcast until new accepts occur.
- Simultaneous events:
  - flush beats accept and grant;
  - on a slot, grant plus accept in the same cycle means refill (slot stays valid with the new tag).

## Test plan

- Reset/idle:
  - assert reset_n=0 mid-cycle;
  - outputs go to 0 asynchronously;
  - after release, fu_ready=5'b11111 and cdb_valid stays 0 with no inputs.
- Single result:
  - ALU presents tag 6'd17 at edge 1;
  - cdb_valid=1, cdb_tag=17, cdb_src=0 in the cycle after edge 2 only.
- All five units present tags 10..14 at one edge, with rr_ptr=0:
  - broadcasts 10,11,12,13,14 on five consecutive cycles, cdb_src 0..4;
  - fu_ready[i] stays low until slot i is granted;
  - rr_ptr wraps to 0.
- Back-to-back single unit:
  - FP1 presents tags 20,21,22 on consecutive edges, others idle;
  - consecutive broadcasts 20,21,22 with cdb_src=3 and no bubble;
  - fu_ready[3] stays 1 throughout.
- Contention and back-pressure:
  - LD and FP2 hold requests continuously with new tags each acceptance;
  - grants alternate between 1 and 4;
  - each unit's fu_ready toggles high only on its grant cycle;
  - no tag is lost or duplicated.
- Flush:
  - with slots 0 and 3 full and ALU presenting tag 30 during flush;
  - next cycle cdb_valid=0, all slots empty, tag 30 never broadcast;
  - rr_ptr is unchanged.
